// File: rtl/adc_ad4003_sdo_emu.sv
// -----------------------------------------------------------------------------
// adc_ad4003_sdo_emu
//
// Transmit-side emulator of the AD4003 serial data output. It stands in for the
// physical converter in loopback/self-test builds so that the SDO reader path
// can be exercised without real silicon.
//
// A sample word is taken from the stimulus source into a one-deep holding
// register. A CNV rising edge moves that word into the shift register and
// starts a modelled conversion time. The word is then shifted out MSB-first,
// one bit per SCK falling edge. If no fresh word is waiting when CNV rises, the
// previously transmitted word is sent again and the underrun flag is raised.
//
// Ports
//   clk           in   system clock; all logic on the rising edge
//   rstn          in   synchronous reset, active low
//   sample_data   in   next sample word to transmit
//   sample_valid  in   sample_data valid
//   sample_ready  out  holding register empty (accept on valid & ready)
//   cnv           in   conversion start, synchronous to clk
//   sck           in   serial clock from the reader, oversampled by clk
//   sdo           out  serial data, MSB first
//   busy          out  high while converting or shifting
//   err_clr       in   clears the sticky flags
//   cnv_err       out  sticky: CNV rising edge while busy
//   underrun      out  sticky: conversion started with holding register empty
// -----------------------------------------------------------------------------
module adc_ad4003_sdo_emu #(
  parameter int ADC_DATA_WIDTH = 18,
  parameter int CONV_CYCLES    = 40,
  parameter int TCQ            = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [ADC_DATA_WIDTH-1:0] sample_data,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic                      cnv,
  input  logic                      sck,
  output logic                      sdo,
  output logic                      busy,
  input  logic                      err_clr,
  output logic                      cnv_err,
  output logic                      underrun
);

  // Conversion counter is sized for the full legal CONV_CYCLES range (1..1023).
  localparam int CNT_W = 10;
  localparam int BIT_W = $clog2(ADC_DATA_WIDTH);

  localparam logic [CNT_W-1:0] CONV_LOAD = CNT_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD  = BIT_W'(ADC_DATA_WIDTH - 1);

  // The model is zero-delay; TCQ is kept so existing instantiations that set it
  // still elaborate. A negative value has no meaning and selects nothing.
  generate
    if (TCQ < 0) begin : g_tcq_negative
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHIFT   = 2'd2
  } state_t;

  // Registered state
  state_t                      r_state;
  logic                        r_cnv_q;
  logic                        r_sck_q;
  logic [ADC_DATA_WIDTH-1:0]   r_hold;
  logic                        r_hold_full;
  logic [ADC_DATA_WIDTH-1:0]   r_last;
  logic [ADC_DATA_WIDTH-1:0]   r_shift;
  logic [CNT_W-1:0]            r_conv_cnt;
  logic [BIT_W-1:0]            r_bit_cnt;
  logic                        r_sdo;
  logic                        r_busy;
  logic                        r_cnv_err;
  logic                        r_underrun;

  // Next-state values
  state_t                      w_state_nxt;
  logic [ADC_DATA_WIDTH-1:0]   w_hold_nxt;
  logic                        w_hold_full_nxt;
  logic [ADC_DATA_WIDTH-1:0]   w_last_nxt;
  logic [ADC_DATA_WIDTH-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]            w_conv_cnt_nxt;
  logic [BIT_W-1:0]            w_bit_cnt_nxt;
  logic                        w_sdo_nxt;
  logic                        w_busy_nxt;
  logic                        w_cnv_err_set;
  logic                        w_underrun_set;
  logic                        w_cnv_err_nxt;
  logic                        w_underrun_nxt;

  // Edge detection against the one-cycle-delayed copies
  logic w_cnv_rise;
  logic w_sck_fall;
  logic w_accept;

  assign w_cnv_rise = cnv & ~r_cnv_q;
  assign w_sck_fall = ~sck & r_sck_q;
  assign w_accept   = sample_valid & ~r_hold_full;

  assign sample_ready = ~r_hold_full;
  assign sdo          = r_sdo;
  assign busy         = r_busy;
  assign cnv_err      = r_cnv_err;
  assign underrun     = r_underrun;

  // Next-state, datapath and output decode for the transmit sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_last_nxt      = r_last;
    w_shift_nxt     = r_shift;
    w_conv_cnt_nxt  = r_conv_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_sdo_nxt       = 1'b0;
    w_busy_nxt      = r_busy;
    w_cnv_err_set   = 1'b0;
    w_underrun_set  = 1'b0;

    // A handshake only completes while the holding register is empty, so it
    // can never collide with a CNV draining a full holding register below.
    if (w_accept) begin
      w_hold_nxt      = sample_data;
      w_hold_full_nxt = 1'b1;
    end else begin
      w_hold_nxt      = r_hold;
    end

    case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
        w_sdo_nxt  = 1'b0;
        if (w_cnv_rise) begin
          w_state_nxt    = ST_CONVERT;
          w_busy_nxt     = 1'b1;
          w_conv_cnt_nxt = CONV_LOAD;
          if (r_hold_full) begin
            w_shift_nxt     = r_hold;
            w_last_nxt      = r_hold;
            w_hold_full_nxt = 1'b0;
          end else begin
            // Nothing fresh to send: repeat the previous word. A word accepted
            // in this same cycle stays in holding for the next conversion.
            w_shift_nxt    = r_last;
            w_last_nxt     = r_last;
            w_underrun_set = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_CONVERT: begin
        w_busy_nxt = 1'b1;
        w_sdo_nxt  = 1'b0;
        if (w_cnv_rise) begin
          w_cnv_err_set = 1'b1;
        end else begin
          w_cnv_err_set = 1'b0;
        end
        // SCK is deliberately not looked at here, including on the final
        // cycle: the MSB must be presented before any SCK edge counts.
        if (r_conv_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt   = ST_SHIFT;
          w_sdo_nxt     = r_shift[ADC_DATA_WIDTH-1];
          w_bit_cnt_nxt = BIT_LOAD;
        end else begin
          w_conv_cnt_nxt = r_conv_cnt - CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        w_busy_nxt = 1'b1;
        w_sdo_nxt  = r_sdo;
        if (w_cnv_rise) begin
          w_cnv_err_set = 1'b1;
        end else begin
          w_cnv_err_set = 1'b0;
        end
        if (w_sck_fall) begin
          if (r_bit_cnt == {BIT_W{1'b0}}) begin
            // Falling edge after the LSB closes the frame.
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_sdo_nxt   = 1'b0;
          end else begin
            w_sdo_nxt     = r_shift[ADC_DATA_WIDTH-2];
            w_shift_nxt   = {r_shift[ADC_DATA_WIDTH-2:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt - BIT_W'(1);
          end
        end else begin
          w_sdo_nxt = r_sdo;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_sdo_nxt   = 1'b0;
      end
    endcase

    // Sticky flags: a set event in the same cycle as err_clr wins.
    if (w_cnv_err_set) begin
      w_cnv_err_nxt = 1'b1;
    end else if (err_clr) begin
      w_cnv_err_nxt = 1'b0;
    end else begin
      w_cnv_err_nxt = r_cnv_err;
    end

    if (w_underrun_set) begin
      w_underrun_nxt = 1'b1;
    end else if (err_clr) begin
      w_underrun_nxt = 1'b0;
    end else begin
      w_underrun_nxt = r_underrun;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath, edge-detect history, outputs and sticky flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnv_q     <= 1'b0;
      r_sck_q     <= 1'b0;
      r_hold      <= {ADC_DATA_WIDTH{1'b0}};
      r_hold_full <= 1'b0;
      r_last      <= {ADC_DATA_WIDTH{1'b0}};
      r_shift     <= {ADC_DATA_WIDTH{1'b0}};
      r_conv_cnt  <= {CNT_W{1'b0}};
      r_bit_cnt   <= {BIT_W{1'b0}};
      r_sdo       <= 1'b0;
      r_busy      <= 1'b0;
      r_cnv_err   <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_cnv_q     <= cnv;
      r_sck_q     <= sck;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_last      <= w_last_nxt;
      r_shift     <= w_shift_nxt;
      r_conv_cnt  <= w_conv_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_sdo       <= w_sdo_nxt;
      r_busy      <= w_busy_nxt;
      r_cnv_err   <= w_cnv_err_nxt;
      r_underrun  <= w_underrun_nxt;
    end
  end

endmodule
